uart_rx: RTL and testbench

//  8N1 UART receiver, the receive-side counterpart of the existing uart transmitter.

---
 rtl/uart_rx_pkg.sv | 11 +
 rtl/uart_rx_sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 101 ++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receiver state encoding and baud constant.
package uart_rx_pkg;
    localparam int UART_CLKS_PER_BIT_115200 = 434;
    typedef enum logic [2:0] {
        RX_STATE_IDLE  = 3'd0,
        RX_STATE_START = 3'd1,
        RX_STATE_DATA  = 3'd2,
        RX_STATE_STOP  = 3'd3,
        RX_STATE_BREAK = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: two-flop synchroniser with a configurable reset value.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-cycle dataReady and framingError strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       framingError,
    output logic       busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d, data_q, data_d;
    logic            ready_q, ready_d, ferr_q, ferr_d;

    uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk_50 (clk_50),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_s)
    );

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q <= RX_STATE_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_STATE_IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = RX_STATE_START;
            end
            RX_STATE_START: if (timer_q == HALF_LAST) begin
                timer_d = '0;
                idx_d   = '0;
                state_d = rx_s ? RX_STATE_IDLE : RX_STATE_DATA;
            end
            RX_STATE_DATA: if (timer_q == BIT_LAST) begin
                timer_d = '0;
                shreg_d = {rx_s, shreg_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = RX_STATE_STOP;
            end
            RX_STATE_STOP: if (timer_q == BIT_LAST) begin
                timer_d = '0;
                data_d  = rx_s ? shreg_q : data_q;
                ready_d = rx_s;
                ferr_d  = !rx_s;
                state_d = rx_s ? RX_STATE_IDLE : RX_STATE_BREAK;
            end
            // A held-low line must rise before another start bit can be detected.
            RX_STATE_BREAK: begin
                timer_d = '0;
                if (rx_s) state_d = RX_STATE_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = RX_STATE_IDLE;
            end
        endcase
    end

    assign data         = data_q;
    assign dataReady    = ready_q;
    assign framingError = ferr_q;
    assign busy         = (state_q != RX_STATE_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven and sequence checks for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       dataReady, framingError, busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    bit busy_seen = 0;
    logic [7:0] rx_q[$];
    int         rt_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50      (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .data        (data),
        .dataReady   (dataReady),
        .framingError(framingError),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataReady) begin
            rx_q.push_back(data);
            rt_q.push_back(cyc);
        end
        if (framingError) ferr_cnt++;
        if (dataReady && framingError) both_cnt++;
        if (busy) busy_seen = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_rdy;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];
    string msg;
    logic [7:0] last_good;
    int t0, r0, f0;

    initial begin
        vecs[0] = '{8'h48, 1'b1, 8'h48, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
        vecs[5] = '{8'h7E, 1'b1, 8'h7E, 1, 0};
        msg = "Hello, everyweeks!\r\n";

        repeat (3) @(negedge clk);
        chk("reset data", data, 8'h00);
        chk("reset dataReady", dataReady, 1'b0);
        chk("reset framingError", framingError, 1'b0);
        chk("reset busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Test 1: 'H' latency, strobe width and busy fall.
        rx_q.delete(); rt_q.delete();
        t0 = cyc;
        send_byte(8'h48, 1'b1);
        repeat (8) @(negedge clk);
        chk("t1 pulses", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            chk("t1 data", rx_q[0], 8'h48);
            chk("t1 latency", rt_q[0] - t0, 155);
        end
        chk("t1 ferr", ferr_cnt, 0);

        // Test 1b: busy is low on the strobe cycle.
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        rx = 1'b1;
        while (!dataReady && cyc - t0 < 200) @(negedge clk);
        chk("t1 strobe seen", dataReady, 1'b1);
        chk("t1 busy on strobe", busy, 1'b0);
        chk("t1 strobe offset", cyc - t0, 155);
        @(negedge clk);
        chk("t1 strobe one cycle", dataReady, 1'b0);
        repeat (8) @(negedge clk);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            r0 = rx_q.size();
            f0 = ferr_cnt;
            send_byte(vecs[v].b, vecs[v].stop);
            repeat (24) @(negedge clk);
            chk($sformatf("vec%0d ready", v), rx_q.size() - r0, vecs[v].exp_rdy);
            chk($sformatf("vec%0d ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            chk($sformatf("vec%0d data", v), data, vecs[v].exp_data);
            chk($sformatf("vec%0d busy", v), busy, 1'b0);
        end
        last_good = 8'h7E;

        // Test 2: back-to-back frames with no idle gap.
        rx_q.delete(); rt_q.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        repeat (20) @(negedge clk);
        chk("t2 pulses", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t2 byte0", rx_q[0], 8'h55);
            chk("t2 byte1", rx_q[1], 8'hA3);
            chk("t2 spacing", rt_q[1] - rt_q[0], 160);
        end
        last_good = 8'hA3;

        // Test 3: 4-cycle glitch on an idle line.
        rx_q.delete(); rt_q.delete();
        f0 = ferr_cnt;
        busy_seen = 0;
        t0 = cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        while (cyc - t0 < 13) @(negedge clk);
        chk("t3 busy pulsed", busy_seen, 1'b1);
        chk("t3 idle restored", busy, 1'b0);
        repeat (200) @(negedge clk);
        chk("t3 no ready", rx_q.size(), 0);
        chk("t3 no ferr", ferr_cnt - f0, 0);

        // Test 4: framing error followed by a held-low break.
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_bit(1'b0);
        repeat (40) @(negedge clk);
        chk("t4 ferr pulse", ferr_cnt - f0, 1);
        chk("t4 data held", data, last_good);
        chk("t4 busy in break", busy, 1'b1);
        chk("t4 no ready", rx_q.size(), 0);
        t0 = cyc;
        rx = 1'b1;
        while (cyc - t0 < 2) @(negedge clk);
        chk("t4 busy until sync", busy, 1'b1);
        @(negedge clk);
        chk("t4 busy drops", busy, 1'b0);
        repeat (8) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (24) @(negedge clk);
        chk("t4 recovery pulses", rx_q.size(), 1);
        chk("t4 recovery data", data, 8'h7E);
        chk("t4 ferr single", ferr_cnt - f0, 1);

        // Test 5: reset mid-frame during data bit 4 (byte 0xF0).
        rx_q.delete(); rt_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5 reset data", data, 8'h00);
        chk("t5 reset ready", dataReady, 1'b0);
        chk("t5 reset ferr", framingError, 1'b0);
        chk("t5 reset busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (8 + 4 * CPB + 30) @(negedge clk);
        chk("t5 frame discarded", rx_q.size(), 0);
        chk("t5 no busy after", busy, 1'b0);
        send_byte(8'h31, 1'b1);
        repeat (24) @(negedge clk);
        chk("t5 follow pulses", rx_q.size(), 1);
        chk("t5 follow data", data, 8'h31);

        // Test 6: string stream, one idle bit between frames as a transmitter would.
        rx_q.delete(); rt_q.delete();
        f0 = ferr_cnt;
        for (int i = 0; i < msg.len(); i++) begin
            send_byte(msg[i], 1'b1);
            send_bit(1'b1);
        end
        repeat (24) @(negedge clk);
        chk("t6 pulses", rx_q.size(), 20);
        for (int i = 0; i < msg.len() && i < rx_q.size(); i++)
            chk($sformatf("t6 byte%0d", i), rx_q[i], msg[i]);
        chk("t6 ferr", ferr_cnt - f0, 0);
        chk("strobes exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
